// File: rtl/pwm_sched_if.sv
// Write channel into the PWM scheduler: a held request carrying a new
// period/duty pair, answered by a one-cycle acknowledge once the shadow
// registers have taken the values.
interface pwm_sched_if #(
    parameter int WIDTH = 8
);
    logic             wr_req;
    logic [WIDTH-1:0] wr_period;
    logic [WIDTH-1:0] wr_duty;
    logic             wr_ack;

    // Requester side (control/register logic)
    modport master (
        output wr_req,
        output wr_period,
        output wr_duty,
        input  wr_ack
    );

    // Scheduler side
    modport slave (
        input  wr_req,
        input  wr_period,
        input  wr_duty,
        output wr_ack
    );
endinterface

// File: rtl/pwm_sched.sv
// Single-channel PWM scheduler.
// Owns the period counter, the active and shadow period/duty registers and the
// IDLE/RUN/STOP sequencing. New settings land in the shadow registers through
// the write channel and are moved into the active set only when idle or at a
// period boundary, so no period is ever cut short or built from mixed settings.
// All outputs are registers, computed from the next-state values so that each
// output describes the cycle that the counter is currently in.
module pwm_sched #(
    parameter int WIDTH = 8
) (
    input  logic             ck,
    input  logic             rst_n,
    input  logic             en,
    pwm_sched_if.slave       wr,
    output logic             pwm,
    output logic [WIDTH-1:0] cnt,
    output logic             period_end,
    output logic             pending,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_STOP = 2'b10
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;

    logic [WIDTH-1:0] per_a_r;
    logic [WIDTH-1:0] duty_a_r;
    logic [WIDTH-1:0] per_s_r;
    logic [WIDTH-1:0] duty_s_r;
    logic             pend_r;
    logic [WIDTH-1:0] cnt_r;
    logic             pwm_r;
    logic             period_end_r;
    logic             wr_ack_r;

    logic [WIDTH-1:0] per_a_nxt_s;
    logic [WIDTH-1:0] duty_a_nxt_s;
    logic [WIDTH-1:0] per_s_nxt_s;
    logic [WIDTH-1:0] duty_s_nxt_s;
    logic             pend_nxt_s;
    logic [WIDTH-1:0] cnt_nxt_s;
    logic             pwm_nxt_s;
    logic             period_end_nxt_s;
    logic             capture_s;
    logic             boundary_s;
    logic             load_s;
    logic             run_nxt_s;

    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};

    // Settings transfer, next counter value, next FSM state and next outputs
    always_comb begin
        per_a_nxt_s      = per_a_r;
        duty_a_nxt_s     = duty_a_r;
        per_s_nxt_s      = per_s_r;
        duty_s_nxt_s     = duty_s_r;
        pend_nxt_s       = pend_r;
        cnt_nxt_s        = cnt_r;
        state_nxt_s      = state_r;
        run_nxt_s        = 1'b0;
        pwm_nxt_s        = 1'b0;
        period_end_nxt_s = 1'b0;

        // A held request is taken only while the shadow is free; this is what
        // stops one long request from being captured twice.
        capture_s  = wr.wr_req && !pend_r;
        boundary_s = (state_r != ST_IDLE) && (cnt_r == per_a_r);
        load_s     = pend_r && ((state_r == ST_IDLE) || boundary_s);

        // Load and capture are mutually exclusive: one needs pend set, the
        // other needs it clear. A capture on a boundary edge therefore waits
        // for the following boundary.
        if (load_s) begin
            per_a_nxt_s  = per_s_r;
            duty_a_nxt_s = duty_s_r;
            pend_nxt_s   = 1'b0;
        end else if (capture_s) begin
            per_s_nxt_s  = wr.wr_period;
            duty_s_nxt_s = wr.wr_duty;
            pend_nxt_s   = 1'b1;
        end else begin
            pend_nxt_s   = pend_r;
        end

        case (state_r)
            ST_IDLE: begin
                cnt_nxt_s = ZERO_W;
                // Decide on the period that is in force after any load on
                // this edge; a zero period never starts.
                if (en && (per_a_nxt_s != ZERO_W)) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN, ST_STOP: begin
                if (boundary_s) begin
                    cnt_nxt_s = ZERO_W;
                    if (en && (per_a_nxt_s != ZERO_W)) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    cnt_nxt_s = cnt_r + ONE_W;
                    if (en) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_STOP;
                    end
                end
            end
            default: begin
                cnt_nxt_s   = ZERO_W;
                state_nxt_s = ST_IDLE;
            end
        endcase

        run_nxt_s        = (state_nxt_s != ST_IDLE);
        pwm_nxt_s        = run_nxt_s && (cnt_nxt_s < duty_a_nxt_s);
        period_end_nxt_s = run_nxt_s && (cnt_nxt_s == per_a_nxt_s);
    end

    // FSM state register
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Active/shadow settings, pending flag and period counter
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            per_a_r  <= ZERO_W;
            duty_a_r <= ZERO_W;
            per_s_r  <= ZERO_W;
            duty_s_r <= ZERO_W;
            pend_r   <= 1'b0;
            cnt_r    <= ZERO_W;
        end else begin
            per_a_r  <= per_a_nxt_s;
            duty_a_r <= duty_a_nxt_s;
            per_s_r  <= per_s_nxt_s;
            duty_s_r <= duty_s_nxt_s;
            pend_r   <= pend_nxt_s;
            cnt_r    <= cnt_nxt_s;
        end
    end

    // Registered outputs describing the cycle the counter is now in
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            pwm_r        <= 1'b0;
            period_end_r <= 1'b0;
            wr_ack_r     <= 1'b0;
        end else begin
            pwm_r        <= pwm_nxt_s;
            period_end_r <= period_end_nxt_s;
            wr_ack_r     <= capture_s;
        end
    end

    assign pwm        = pwm_r;
    assign cnt        = cnt_r;
    assign period_end = period_end_r;
    assign pending    = pend_r;
    assign state      = state_r;
    assign wr.wr_ack  = wr_ack_r;

endmodule

// File: tb/tb_pwm_sched.sv
// Bench for pwm_sched: a hand-derived vector table, directed sequences for the
// multi-cycle corners (async reset, edge duties, zero period, STOP/RUN) and a
// randomized run against a rule-level reference model.
module tb_pwm_sched;

    logic       ck;
    logic       rst_n;
    logic       en;
    logic       pwm;
    logic [7:0] cnt;
    logic       period_end;
    logic       pending;
    logic [1:0] state;

    pwm_sched_if #(.WIDTH(8)) wr_if ();

    pwm_sched #(.WIDTH(8)) dut (
        .ck         (ck),
        .rst_n      (rst_n),
        .en         (en),
        .wr         (wr_if),
        .pwm        (pwm),
        .cnt        (cnt),
        .period_end (period_end),
        .pending    (pending),
        .state      (state)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    int total = 0;
    int bad   = 0;

    // Output snapshot: {state, cnt, pwm, period_end, pending, wr_ack}
    function automatic logic [13:0] snap();
        return {state, cnt, pwm, period_end, pending, wr_if.wr_ack};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic e, input logic rq, input logic [7:0] p, input logic [7:0] d);
        en              = e;
        wr_if.wr_req    = rq;
        wr_if.wr_period = p;
        wr_if.wr_duty   = d;
        @(posedge ck);
        #1;
    endtask

    // Hold a request until acknowledged (bounded), then drop it
    task automatic write(input logic [7:0] p, input logic [7:0] d);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            drive(en, 1'b1, p, d);
            got = wr_if.wr_ack;
        end
        wr_if.wr_req = 1'b0;
        if (!got) check("write_ack_timeout", 32'd0, 32'd1);
    endtask

    // Bring the block to IDLE, write new settings and let them apply
    task automatic config_idle(input logic [7:0] p, input logic [7:0] d);
        bit idle;
        idle = (state == 2'b00);
        for (int i = 0; i < 300 && !idle; i++) begin
            drive(1'b0, 1'b0, 8'd0, 8'd0);
            idle = (state == 2'b00);
        end
        if (!idle) check("idle_timeout", 32'd0, 32'd1);
        en = 1'b0;
        write(p, d);
        drive(1'b0, 1'b0, 8'd0, 8'd0);
        check("cfg_applied_pending", 32'(pending), 32'd0);
    endtask

    task automatic wait_cnt(input logic [7:0] v);
        bit hit;
        hit = (cnt == v);
        for (int i = 0; i < 50 && !hit; i++) begin
            drive(en, 1'b0, 8'd0, 8'd0);
            hit = (cnt == v);
        end
        if (!hit) check("wait_cnt_timeout", 32'(cnt), 32'(v));
    endtask

    // ---------------- reference model ----------------
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_STOP = 2;

    int  m_mode, m_cnt, m_per, m_duty, m_sh_per, m_sh_duty;
    bit  m_full, m_ack;

    task automatic model_reset();
        m_mode = M_IDLE; m_cnt = 0; m_per = 0; m_duty = 0;
        m_sh_per = 0; m_sh_duty = 0; m_full = 1'b0; m_ack = 1'b0;
    endtask

    task automatic model_step(input bit e, input bit rq, input int p, input int d);
        bit period_done;
        bit may_start;
        period_done = (m_mode != M_IDLE) && (m_cnt == m_per);
        may_start   = (m_mode == M_IDLE) || period_done;
        m_ack = 1'b0;
        if (m_full && may_start) begin
            m_per  = m_sh_per;
            m_duty = m_sh_duty;
            m_full = 1'b0;
        end else if (rq && !m_full) begin
            m_sh_per  = p;
            m_sh_duty = d;
            m_full    = 1'b1;
            m_ack     = 1'b1;
        end
        if (may_start) begin
            m_cnt  = 0;
            m_mode = (e && m_per != 0) ? M_RUN : M_IDLE;
        end else begin
            m_cnt  = m_cnt + 1;
            m_mode = e ? M_RUN : M_STOP;
        end
    endtask

    function automatic logic [13:0] model_snap();
        bit active;
        active = (m_mode != M_IDLE);
        return {2'(m_mode), 8'(m_cnt), active && (m_cnt < m_duty),
                active && (m_cnt == m_per), m_full, m_ack};
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        logic       en;
        logic       req;
        logic [7:0] per;
        logic [7:0] duty;
        logic [1:0] st;
        logic [7:0] c;
        logic       pw;
        logic       pe;
        logic       pd;
        logic       ak;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic e, input logic rq, input logic [7:0] p, input logic [7:0] d,
                       input logic [1:0] st, input logic [7:0] c, input logic pw,
                       input logic pe, input logic pd, input logic ak);
        vec_t v;
        v.en = e; v.req = rq; v.per = p; v.duty = d;
        v.st = st; v.c = c; v.pw = pw; v.pe = pe; v.pd = pd; v.ak = ak;
        vecs.push_back(v);
    endtask

    bit         r_req;
    logic [7:0] r_per, r_duty;
    bit         r_en;

    initial begin
        rst_n = 1'b0;
        en = 1'b0;
        wr_if.wr_req = 1'b0;
        wr_if.wr_period = 8'd0;
        wr_if.wr_duty = 8'd0;

        //   en rq per duty | st cnt pwm pe pend ack
        add(1'b0, 1'b1, 8'd4, 8'd2, 2'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        add(1'b0, 1'b0, 8'd0, 8'd0, 2'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 8'd0, 8'd0, 2'd1, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 8'd0, 8'd0, 2'd1, 8'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 8'd0, 8'd0, 2'd1, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 8'd0, 8'd0, 2'd1, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 8'd0, 8'd0, 2'd1, 8'd4, 1'b0, 1'b1, 1'b0, 1'b0);
        add(1'b1, 1'b0, 8'd0, 8'd0, 2'd1, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 8'd0, 8'd0, 2'd1, 8'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b1, 8'd7, 8'd6, 2'd1, 8'd2, 1'b0, 1'b0, 1'b1, 1'b1);
        add(1'b1, 1'b0, 8'd0, 8'd0, 2'd1, 8'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        add(1'b1, 1'b0, 8'd0, 8'd0, 2'd1, 8'd4, 1'b0, 1'b1, 1'b1, 1'b0);
        add(1'b1, 1'b0, 8'd0, 8'd0, 2'd1, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b1, 8'd3, 8'd1, 2'd1, 8'd1, 1'b1, 1'b0, 1'b1, 1'b1);
        add(1'b1, 1'b1, 8'd2, 8'd2, 2'd1, 8'd2, 1'b1, 1'b0, 1'b1, 1'b0);
        add(1'b1, 1'b1, 8'd2, 8'd2, 2'd1, 8'd3, 1'b1, 1'b0, 1'b1, 1'b0);
        add(1'b1, 1'b1, 8'd2, 8'd2, 2'd1, 8'd4, 1'b1, 1'b0, 1'b1, 1'b0);
        add(1'b1, 1'b1, 8'd2, 8'd2, 2'd1, 8'd5, 1'b1, 1'b0, 1'b1, 1'b0);
        add(1'b1, 1'b1, 8'd2, 8'd2, 2'd1, 8'd6, 1'b0, 1'b0, 1'b1, 1'b0);
        add(1'b1, 1'b1, 8'd2, 8'd2, 2'd1, 8'd7, 1'b0, 1'b1, 1'b1, 1'b0);
        add(1'b1, 1'b1, 8'd2, 8'd2, 2'd1, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b1, 8'd2, 8'd2, 2'd1, 8'd1, 1'b0, 1'b0, 1'b1, 1'b1);
        add(1'b1, 1'b0, 8'd0, 8'd0, 2'd1, 8'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        add(1'b1, 1'b0, 8'd0, 8'd0, 2'd1, 8'd3, 1'b0, 1'b1, 1'b1, 1'b0);
        add(1'b1, 1'b0, 8'd0, 8'd0, 2'd1, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 8'd0, 8'd0, 2'd1, 8'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 8'd0, 8'd0, 2'd1, 8'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        add(1'b1, 1'b0, 8'd0, 8'd0, 2'd1, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 8'd0, 8'd0, 2'd2, 8'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 8'd0, 8'd0, 2'd2, 8'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 8'd0, 8'd0, 2'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 8'd0, 8'd0, 2'd1, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Reset state
        #12;
        check("reset_outputs", 32'(snap()), 32'd0);
        #10 rst_n = 1'b1;
        @(posedge ck);
        #1;
        check("idle_after_reset", 32'(snap()), 32'd0);

        // Vector table
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].en, vecs[i].req, vecs[i].per, vecs[i].duty);
            check($sformatf("vec%0d", i), 32'(snap()),
                  32'({vecs[i].st, vecs[i].c, vecs[i].pw, vecs[i].pe, vecs[i].pd, vecs[i].ak}));
        end

        // Async reset mid-RUN with per=5 duty=2
        config_idle(8'd5, 8'd2);
        drive(1'b1, 1'b0, 8'd0, 8'd0);
        drive(1'b1, 1'b0, 8'd0, 8'd0);
        check("pre_reset_running", 32'(state), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        check("async_reset_outputs", 32'(snap()), 32'd0);
        #20 rst_n = 1'b1;
        drive(1'b0, 1'b0, 8'd0, 8'd0);
        check("post_reset_state", 32'(state), 32'd0);
        check("post_reset_pending", 32'(pending), 32'd0);

        // Edge duties with per=3
        config_idle(8'd3, 8'd0);
        en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 1'b0, 8'd0, 8'd0);
            check("duty0_pwm", 32'({state, pwm}), 32'({2'd1, 1'b0}));
        end
        config_idle(8'd3, 8'd4);
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 1'b0, 8'd0, 8'd0);
            check("duty4_pwm", 32'({state, pwm}), 32'({2'd1, 1'b1}));
        end
        config_idle(8'd3, 8'd255);
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 1'b0, 8'd0, 8'd0);
            check("duty255_pwm", 32'({state, pwm}), 32'({2'd1, 1'b1}));
        end

        // Zero period loaded at a boundary stops the output
        en = 1'b1;
        write(8'd0, 8'd0);
        begin
            bit cleared;
            cleared = (pending == 1'b0);
            for (int i = 0; i < 20 && !cleared; i++) begin
                drive(1'b1, 1'b0, 8'd0, 8'd0);
                cleared = (pending == 1'b0);
            end
            if (!cleared) check("per0_load_timeout", 32'd0, 32'd1);
        end
        check("per0_idle", 32'({state, cnt, pwm}), 32'd0);
        drive(1'b1, 1'b0, 8'd0, 8'd0);
        drive(1'b1, 1'b0, 8'd0, 8'd0);
        check("per0_stays_idle", 32'(state), 32'd0);

        // STOP re-raised at cnt=2, then STOP completing to IDLE
        config_idle(8'd4, 8'd2);
        en = 1'b1;
        wait_cnt(8'd1);
        drive(1'b0, 1'b0, 8'd0, 8'd0);
        check("stop_entered", 32'({state, cnt}), 32'({2'd2, 8'd2}));
        drive(1'b1, 1'b0, 8'd0, 8'd0);
        check("rerun_no_gap", 32'({state, cnt}), 32'({2'd1, 8'd3}));
        wait_cnt(8'd1);
        drive(1'b0, 1'b0, 8'd0, 8'd0);
        drive(1'b0, 1'b0, 8'd0, 8'd0);
        drive(1'b0, 1'b0, 8'd0, 8'd0);
        check("stop_last", 32'({state, cnt, pwm, period_end}), 32'({2'd2, 8'd4, 1'b0, 1'b1}));
        drive(1'b0, 1'b0, 8'd0, 8'd0);
        check("stop_to_idle", 32'({state, cnt, pwm}), 32'd0);

        // Randomized run against the reference model
        rst_n = 1'b0;
        #7 rst_n = 1'b1;
        model_reset();
        r_req = 1'b0; r_per = 8'd0; r_duty = 8'd0;
        for (int i = 0; i < 3000; i++) begin
            if (r_req && wr_if.wr_ack) r_req = 1'b0;
            if (!r_req && $urandom_range(0, 5) == 0) begin
                r_req  = 1'b1;
                r_per  = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 9));
                r_duty = 8'($urandom_range(0, 11));
            end
            r_en = ($urandom_range(0, 9) < 8);
            model_step(r_en, r_req, int'(r_per), int'(r_duty));
            drive(r_en, r_req, r_per, r_duty);
            check("random", 32'(snap()), 32'(model_snap()));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pwm_sched.md
# pwm_sched

Single-channel PWM scheduler: owns the period counter, the active and shadow period/duty registers, and the run/stop sequencing for one PWM output. Software-side logic writes new settings through a req/ack handshake. The block applies them only at period boundaries, or immediately when idle, so the output never shows a truncated or mixed-setting period. It sits between the control/register logic and the output flip-flop stage of the PWM path.

## Interface
- WIDTH, 8, width of counter, period and duty values

- ck  in  1  clock, all state changes on rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  run request; level-sensitive
- wr_req  in  1  write request; held high with data stable until wr_ack
- wr_period  in  WIDTH  new period value (period length = wr_period+1 cycles)
- wr_duty  in  WIDTH  new duty value (high cycles per period)
- wr_ack  out  1  one-cycle pulse: shadow captured
- pwm  out  1  PWM output, registered
- cnt  out  WIDTH  current period count
- period_end  out  1  one-cycle pulse in last cycle of each period (cnt==per_a) in RUN/STOP
- pending  out  1  shadow holds a value not yet applied
- state  out  2  00 IDLE, 01 RUN, 10 STOP

## Operation
- Registers: per_a/duty_a (active), per_s/duty_s (shadow), pend flag, cnt, state.
- Reset (rst_n=0, async): all registers and outputs 0; state IDLE.
- Write handshake: on an edge with wr_req=1 and pend=0, capture wr_period/wr_duty into shadow and set pend. wr_ack=1 in the following cycle only.
- While pend=1, wr_req is not acknowledged; requester waits. pend blocks double capture of a held request.
- IDLE: cnt=0, pwm=0. If pend=1, transfer shadow→active on the next edge and clear pend. If en=1 and per_a!=0, go to RUN with cnt=0. If en=1 and per_a==0, stay in IDLE.
- RUN: cnt increments by 1 each cycle. When cnt==per_a: period_end=1, cnt wraps to 0, and if pend=1 load shadow→active and clear pend.
- en=0 during RUN → STOP on the next edge. STOP counts exactly like RUN and finishes the current period.
- STOP at the boundary → IDLE with cnt=0, pwm=0. en=1 again before the boundary → back to RUN with no counter disturbance.
- Active period 0 after a boundary load → IDLE; a 1-cycle period never runs.
- pwm: in any RUN/STOP cycle with cnt==k, pwm=(k<duty_a) for the duty_a in force for that period. duty_a=0 → always low. duty_a>per_a → always high.
- Simultaneous events:
  - Capture on the same edge as a boundary, with pend=0 beforehand: the new values are not applied at that boundary, only at the next one.
  - pend cleared at a boundary: a waiting wr_req is captured on the following edge.

## Timing
- en rises, sampled at edge t in IDLE: state=RUN, cnt=0, pwm=(0<duty_a) from t+1.
- Period length = per_a+1 cycles exactly. period_end high in the cycle cnt==per_a.
- Boundary load takes effect in the cycle with cnt=0 (the first cycle of the new period).
- wr_ack latency: 1 cycle after the capturing edge. Minimum write-to-apply is 1 cycle in IDLE, or up to per_a+1 cycles in RUN.
- rst_n asserted mid-period: outputs go to 0 immediately (asynchronously), without waiting for the boundary. Normal operation resumes on the first edge after release.

## Test plan
- Reset mid-RUN with per=5, duty=2: all outputs 0 asynchronously; after release, state=IDLE and pending=0.
- In IDLE, write per=4, duty=2, then en=1: wr_ack one cycle; pwm repeats 1,1,0,0,0; period_end every 5th cycle at cnt=4.
- Running per=4/duty=2, write per=7/duty=6 at cnt=1: pending=1 until the boundary. Next period is 8 cycles with 6 high, and the old period completes unaltered.
- Second wr_req while pending=1: no wr_ack until after the boundary, then ack one cycle after the edge following the clear; the value is applied at the next boundary.
- en dropped at cnt=1 (per=4): state=STOP, counting continues to cnt=4, then IDLE with pwm=0. Re-raising en at cnt=2 instead keeps RUN with no gap.
- Edge duties with per=3: duty=0 → pwm constant 0; duty=4 and duty=255 → pwm constant 1. Loading per=0 at a boundary → state IDLE.
